// File: rtl/a_format_pkg.sv
// Shared A-form constants for the instruction encoder and the A-format decoder.
// Holds field positions, format/unit codes, sweep register values and the sweep state enum.
package a_format_pkg;

    localparam int PRIM_OP_POS  = 0;
    localparam int FRT_POS      = 6;
    localparam int FRA_POS      = 11;
    localparam int FRB_POS      = 16;
    localparam int FRC_POS      = 21;
    localparam int XO_POS       = 26;
    localparam int RC_POS       = 31;
    localparam int PRIM_OP_SIZE = 6;
    localparam int REG_SIZE     = 5;
    localparam int XO_SIZE      = 5;

    localparam logic [0:25] A_FORMAT = 26'd2;

    // Functional-unit IDs, kept identical to the decoder's numbering.
    localparam logic [0:1] FU_FXU = 2'd0;
    localparam logic [0:1] FU_FPU = 2'd1;
    localparam logic [0:1] FU_LSU = 2'd2;
    localparam logic [0:1] FU_BRU = 2'd3;

    localparam logic [0:4] SWEEP_FRT         = 5'b01110;
    localparam logic [0:4] SWEEP_FRA         = 5'b10101;
    localparam logic [0:4] SWEEP_FRB         = 5'b01010;
    localparam logic [0:4] SWEEP_FRC         = 5'b10001;
    localparam logic       SWEEP_RC          = 1'b0;
    localparam logic [0:5] SWEEP_LAST_OPCODE = 6'd62;
    localparam logic [0:4] SWEEP_LAST_XO     = 5'd30;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_e;

    function automatic logic [0:31] encodeAForm(
        input logic [0:5] op,
        input logic [0:4] frt,
        input logic [0:4] fra,
        input logic [0:4] frb,
        input logic [0:4] frc,
        input logic [0:4] xo,
        input logic       rc
    );
        return {op, frt, fra, frb, frc, xo, rc};
    endfunction

endpackage

// File: rtl/a_format_skid_buffer.sv
// Registered output stage with a single skid entry; stalls never drop or reorder words.
// Synchronous active-low reset empties both entries and zeroes the held payload.
module a_format_skid_buffer #(
    parameter int Width = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             stall_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             outValid_q, outValid_d;
    logic [Width-1:0] outData_q, outData_d;
    logic             skidValid_q, skidValid_d;
    logic [Width-1:0] skidData_q, skidData_d;

    assign ready_o = !skidValid_q && reset_i;
    assign valid_o = outValid_q;
    assign data_o  = outData_q;

    // The output register refills whenever its word is gone; a blocked push parks in the skid.
    always_comb begin
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        if (!outValid_q || !stall_i) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outData_d   = skidData_q;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = push_i;
                if (push_i) begin
                    outData_d = data_i;
                end
            end
        end else if (push_i) begin
            skidValid_d = 1'b1;
            skidData_d  = data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
        end else begin
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
        end
    end

endmodule

// File: rtl/a_format_inst_encoder.sv
// Packs A-form field tuples into 32-bit POWER words tagged with PC and major ID.
// Optional self-driven opcode/xopcode sweep is built when AFORMAT_ENC_SWEEP_EN is defined.
module a_format_inst_encoder
    import a_format_pkg::*;
#(
    parameter int          addressWidth            = 64,
    parameter int          instructionWidth        = 32,
    parameter int          PidSize                 = 20,
    parameter int          TidSize                 = 16,
    parameter int          instructionCounterWidth = 64,
    parameter int          PrimOpcodeSize          = 6,
    parameter int          regSize                 = 5,
    parameter logic [0:25] A                       = A_FORMAT,
    parameter int          addressStride           = 4
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [0:PrimOpcodeSize-1]            primOpcode_i,
    input  logic [0:regSize-1]                   frt_i,
    input  logic [0:regSize-1]                   fra_i,
    input  logic [0:regSize-1]                   frb_i,
    input  logic [0:regSize-1]                   frc_i,
    input  logic [0:regSize-1]                   xopcode_i,
    input  logic                                 rc_i,
    input  logic                                 loadBase_i,
    input  logic [0:addressWidth-1]              baseAddress_i,
    input  logic                                 is64Bit_i,
    input  logic [0:PidSize-1]                   pid_i,
    input  logic [0:TidSize-1]                   tid_i,
    input  logic                                 stall_i,
`ifdef AFORMAT_ENC_SWEEP_EN
    input  logic                                 sweepStart_i,
    output logic                                 sweepDone_o,
`endif
    output logic                                 enable_o,
    output logic [0:25]                          instFormat_o,
    output logic [0:PrimOpcodeSize-1]            instructionOpcode_o,
    output logic [0:instructionWidth-1]          instruction_o,
    output logic [0:addressWidth-1]              instructionAddress_o,
    output logic                                 is64Bit_o,
    output logic [0:PidSize-1]                   instructionPid_o,
    output logic [0:TidSize-1]                   instructionTid_o,
    output logic [0:instructionCounterWidth-1]   instructionMajId_o
);

    localparam int PayloadWidth = instructionWidth + addressWidth + 1 + PidSize + TidSize
                                  + instructionCounterWidth;

    logic                               accept;
    logic                               skidReady;
    logic [0:instructionWidth-1]        tupleInst;
    logic [0:addressWidth-1]            pc_q, pc_d;
    logic [0:instructionCounterWidth-1] majId_q, majId_d;
    logic [0:addressWidth-1]            baseAligned, tupleAddr, tagAddr;
    logic [PayloadWidth-1:0]            payloadIn, payloadOut;

`ifdef AFORMAT_ENC_SWEEP_EN
    sweep_state_e state_q, state_d;
    logic [0:5]   sweepOp_q, sweepOp_d;
    logic [0:4]   sweepXo_q, sweepXo_d;
    logic         inSweep;
    logic         lastTuple;

    assign inSweep   = (state_q == SWEEP);
    assign lastTuple = (sweepOp_q == SWEEP_LAST_OPCODE) && (sweepXo_q == SWEEP_LAST_XO);
    assign accept    = (inSweep || valid_i) && skidReady;
    assign ready_o   = skidReady && !inSweep;
    assign tupleInst = inSweep
        ? encodeAForm(sweepOp_q, SWEEP_FRT, SWEEP_FRA, SWEEP_FRB, SWEEP_FRC, sweepXo_q, SWEEP_RC)
        : encodeAForm(primOpcode_i, frt_i, fra_i, frb_i, frc_i, xopcode_i, rc_i);

    // Opcode is the outer loop, xopcode the inner; counters rest at zero outside a sweep.
    always_comb begin
        state_d     = state_q;
        sweepOp_d   = sweepOp_q;
        sweepXo_d   = sweepXo_q;
        sweepDone_o = 1'b0;
        case (state_q)
            IDLE: begin
                sweepOp_d = '0;
                sweepXo_d = '0;
                if (sweepStart_i) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (accept) begin
                    if (lastTuple) begin
                        state_d = DONE;
                    end else if (sweepXo_q == SWEEP_LAST_XO) begin
                        sweepXo_d = '0;
                        sweepOp_d = sweepOp_q + 6'd1;
                    end else begin
                        sweepXo_d = sweepXo_q + 5'd1;
                    end
                end
            end
            DONE: begin
                sweepDone_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            sweepOp_q <= '0;
            sweepXo_q <= '0;
        end else begin
            state_q   <= state_d;
            sweepOp_q <= sweepOp_d;
            sweepXo_q <= sweepXo_d;
        end
    end
`else
    assign accept    = valid_i && skidReady;
    assign ready_o   = skidReady;
    assign tupleInst = encodeAForm(primOpcode_i, frt_i, fra_i, frb_i, frc_i, xopcode_i, rc_i);
`endif

    assign baseAligned = {baseAddress_i[0:addressWidth-3], 2'b00};
    assign tupleAddr   = loadBase_i ? baseAligned : pc_q;
    // 32-bit mode hides the upper address half on the tag only; the PC keeps counting in full.
    assign tagAddr     = is64Bit_i ? tupleAddr : {32'b0, tupleAddr[32:addressWidth-1]};

    always_comb begin
        pc_d    = pc_q;
        majId_d = majId_q;
        if (accept) begin
            pc_d    = tupleAddr + addressWidth'(addressStride);
            majId_d = majId_q + instructionCounterWidth'(1);
        end else if (loadBase_i) begin
            pc_d = baseAligned;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            pc_q    <= '0;
            majId_q <= '0;
        end else begin
            pc_q    <= pc_d;
            majId_q <= majId_d;
        end
    end

    assign payloadIn = {tupleInst, tagAddr, is64Bit_i, pid_i, tid_i, majId_q};

    a_format_skid_buffer #(
        .Width(PayloadWidth)
    ) skid (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .push_i (accept),
        .data_i (payloadIn),
        .stall_i(stall_i),
        .ready_o(skidReady),
        .valid_o(enable_o),
        .data_o (payloadOut)
    );

    assign {instruction_o, instructionAddress_o, is64Bit_o, instructionPid_o,
            instructionTid_o, instructionMajId_o} = payloadOut;
    assign instructionOpcode_o = instruction_o[0:PrimOpcodeSize-1];
    assign instFormat_o        = enable_o ? A : '0;

endmodule

// File: tb/tb_a_format_inst_encoder.sv
// Scoreboard bench for a_format_inst_encoder: directed tuples push hand-computed words,
// a negedge monitor pops and compares each consumed output word.
module tb_a_format_inst_encoder;

    localparam logic [19:0] PID_VAL = 20'hABCDE;
    localparam logic [15:0] TID_VAL = 16'h1234;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [0:5]  primOpcode_i = '0;
    logic [0:4]  frt_i = '0, fra_i = '0, frb_i = '0, frc_i = '0, xopcode_i = '0;
    logic        rc_i = 1'b0;
    logic        loadBase_i = 1'b0;
    logic [0:63] baseAddress_i = '0;
    logic        is64Bit_i = 1'b1;
    logic [0:19] pid_i = PID_VAL;
    logic [0:15] tid_i = TID_VAL;
    logic        stall_i = 1'b0;
`ifdef AFORMAT_ENC_SWEEP_EN
    logic        sweepStart_i = 1'b0;
    logic        sweepDone_o;
`endif
    logic        enable_o;
    logic [0:25] instFormat_o;
    logic [0:5]  instructionOpcode_o;
    logic [0:31] instruction_o;
    logic [0:63] instructionAddress_o;
    logic        is64Bit_o;
    logic [0:19] instructionPid_o;
    logic [0:15] instructionTid_o;
    logic [0:63] instructionMajId_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] addr;
        logic [63:0] maj;
        logic        is64;
    } exp_t;

    exp_t sbQueue[$];
    int   vectorCount = 0;
    int   missCount = 0;

    a_format_inst_encoder dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .primOpcode_i        (primOpcode_i),
        .frt_i               (frt_i),
        .fra_i               (fra_i),
        .frb_i               (frb_i),
        .frc_i               (frc_i),
        .xopcode_i           (xopcode_i),
        .rc_i                (rc_i),
        .loadBase_i          (loadBase_i),
        .baseAddress_i       (baseAddress_i),
        .is64Bit_i           (is64Bit_i),
        .pid_i               (pid_i),
        .tid_i               (tid_i),
        .stall_i             (stall_i),
`ifdef AFORMAT_ENC_SWEEP_EN
        .sweepStart_i        (sweepStart_i),
        .sweepDone_o         (sweepDone_o),
`endif
        .enable_o            (enable_o),
        .instFormat_o        (instFormat_o),
        .instructionOpcode_o (instructionOpcode_o),
        .instruction_o       (instruction_o),
        .instructionAddress_o(instructionAddress_o),
        .is64Bit_o           (is64Bit_o),
        .instructionPid_o    (instructionPid_o),
        .instructionTid_o    (instructionTid_o),
        .instructionMajId_o  (instructionMajId_o)
    );

    always #5 clock_i = ~clock_i;

    // A word is consumed at the next edge whenever it is valid and not stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_i);
            if (reset_i && enable_o && !stall_i) begin
                vectorCount++;
                if (sbQueue.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpectedWord: got inst=%h addr=%h maj=%h, required no word",
                             instruction_o, instructionAddress_o, instructionMajId_o);
                end else begin
                    e = sbQueue.pop_front();
                    if (instruction_o !== e.inst || instructionAddress_o !== e.addr ||
                        instructionMajId_o !== e.maj || is64Bit_o !== e.is64 ||
                        instFormat_o !== 26'd2 || instructionOpcode_o !== e.inst[31:26] ||
                        instructionPid_o !== PID_VAL || instructionTid_o !== TID_VAL) begin
                        missCount++;
                        $display("[TB] FAIL word: got inst=%h addr=%h maj=%h is64=%b fmt=%h op=%h pid=%h tid=%h, required inst=%h addr=%h maj=%h is64=%b fmt=2",
                                 instruction_o, instructionAddress_o, instructionMajId_o, is64Bit_o,
                                 instFormat_o, instructionOpcode_o, instructionPid_o, instructionTid_o,
                                 e.inst, e.addr, e.maj, e.is64);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        vectorCount++;
        if (actual !== required) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic doReset();
        reset_i = 1'b0;
        valid_i = 1'b0;
        stall_i = 1'b0;
        loadBase_i = 1'b0;
        repeat (2) @(posedge clock_i);
        sbQueue.delete();
        @(negedge clock_i);
        checkOutput("rstEnable", 64'(enable_o), 64'd0);
        checkOutput("rstReady", 64'(ready_o), 64'd0);
        checkOutput("rstFormat", 64'(instFormat_o), 64'd0);
        checkOutput("rstInst", 64'(instruction_o), 64'd0);
        checkOutput("rstAddr", instructionAddress_o, 64'd0);
        checkOutput("rstMajId", instructionMajId_o, 64'd0);
        checkOutput("rstTags", {is64Bit_o, instructionPid_o, instructionTid_o, instructionOpcode_o}, 64'd0);
        @(posedge clock_i);
        #1 reset_i = 1'b1;
        @(negedge clock_i);
        checkOutput("readyAfterRst", 64'(ready_o), 64'd1);
        @(posedge clock_i);
        #1;
    endtask

    task automatic applyStimulus(
        input logic [5:0]  op,
        input logic [4:0]  frt, fra, frb, frc, xo,
        input logic        rc,
        input logic        lb,
        input logic [63:0] base,
        input logic        is64,
        input logic [31:0] expInst,
        input logic [63:0] expAddr,
        input logic [63:0] expMaj
    );
        bit accepted = 1'b0;
        primOpcode_i = op;
        frt_i = frt; fra_i = fra; frb_i = frb; frc_i = frc; xopcode_i = xo; rc_i = rc;
        loadBase_i = lb;
        baseAddress_i = base;
        is64Bit_i = is64;
        valid_i = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clock_i);
            if (ready_o) begin
                accepted = 1'b1;
                sbQueue.push_back('{inst: expInst, addr: expAddr, maj: expMaj, is64: is64});
            end
            @(posedge clock_i);
            #1;
        end
        valid_i = 1'b0;
        loadBase_i = 1'b0;
        if (!accepted) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL acceptTimeout: got no accept for inst %h, required accept", expInst);
        end
    endtask

    initial begin
        doReset();

        // Single word and its one-cycle latency.
        applyStimulus(6'd63, 5'd1, 5'd2, 5'd3, 5'd4, 5'd21, 1'b1, 1'b0, 64'd0, 1'b1,
                      32'hFC22192B, 64'd0, 64'd0);
        @(negedge clock_i);
        checkOutput("latency", 64'(enable_o), 64'd1);
        repeat (3) @(posedge clock_i);
        #1;

        // Backpressure: two accepted while stalled, third waits.
        doReset();
        stall_i = 1'b1;
        applyStimulus(6'd31, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 1'b0, 1'b0, 64'd0, 1'b1,
                      32'h7CA63A14, 64'd0, 64'd0);
        applyStimulus(6'd1, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 1'b1, 1'b0, 64'd0, 1'b1,
                      32'h041F07C1, 64'd4, 64'd1);
        @(negedge clock_i);
        checkOutput("readyLowSkidFull", 64'(ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            checkOutput("stallHoldInst", 64'(instruction_o), 64'h7CA63A14);
        end
        checkOutput("stallHoldMajId", instructionMajId_o, 64'd0);
        @(posedge clock_i);
        #1 stall_i = 1'b0;
        applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 64'd0, 1'b1,
                      32'h0000003E, 64'd8, 64'd2);

        // Base load coinciding with accept, 32-bit masking and PC wrap.
        applyStimulus(6'd14, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 64'h1003, 1'b1,
                      32'h38600000, 64'h1000, 64'd3);
        applyStimulus(6'd32, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1,
                      32'h80000000, 64'h1004, 64'd4);
        applyStimulus(6'd58, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 64'hFFFF_0000_0000_0000, 1'b0,
                      32'hE8000001, 64'd0, 64'd5);
        applyStimulus(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0,
                      32'h00000000, 64'd4, 64'd6);
        applyStimulus(6'd14, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                      32'h38600000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7);
        applyStimulus(6'd32, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1,
                      32'h80000000, 64'd0, 64'd8);
        repeat (4) @(posedge clock_i);
        #1;
        checkOutput("drainAll", 64'(sbQueue.size()), 64'd0);

        // Reset with both entries occupied discards them.
        stall_i = 1'b1;
        applyStimulus(6'd31, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 1'b0, 1'b0, 64'd0, 1'b1,
                      32'h7CA63A14, 64'd0, 64'd0);
        applyStimulus(6'd1, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 1'b1, 1'b0, 64'd0, 1'b1,
                      32'h041F07C1, 64'd4, 64'd1);
        doReset();
        repeat (3) @(negedge clock_i);
        checkOutput("noWordAfterRst", 64'(enable_o), 64'd0);

`ifdef AFORMAT_ENC_SWEEP_EN
        begin
            int doneCount = 0;
            int idx = 0;
            is64Bit_i = 1'b1;
            for (int op = 0; op <= 62; op++) begin
                for (int xo = 0; xo <= 30; xo++) begin
                    sbQueue.push_back('{inst: {6'(op), 5'b01110, 5'b10101, 5'b01010, 5'b10001, 5'(xo), 1'b0},
                                        addr: 64'(idx * 4), maj: 64'(idx), is64: 1'b1});
                    idx++;
                end
            end
            sweepStart_i = 1'b1;
            @(posedge clock_i);
            #1 sweepStart_i = 1'b0;
            for (int i = 0; i < 2100; i++) begin
                @(negedge clock_i);
                if (sweepDone_o) doneCount++;
            end
            checkOutput("sweepDonePulses", 64'(doneCount), 64'd1);
            checkOutput("sweepAllWords", 64'(sbQueue.size()), 64'd0);
            checkOutput("sweepReadyBack", 64'(ready_o), 64'd1);

            stall_i = 1'b1;
            sweepStart_i = 1'b1;
            @(posedge clock_i);
            #1 sweepStart_i = 1'b0;
            repeat (5) @(posedge clock_i);
            #1;
            doReset();
            repeat (3) @(negedge clock_i);
            checkOutput("sweepRstEnable", 64'(enable_o), 64'd0);
            checkOutput("sweepRstDone", 64'(sweepDone_o), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
